seq_divider: RTL

Multi-cycle unsigned restoring divider for the ALU datapath. It computes quotient and remainder by repeated shift-and-subtract, one quotient bit per clock. It is the subtract-direction counterpart of the adder primitives. The ALU control issues a one-cycle start, waits for a done pulse, and reads the held results.

---
 rtl/seq_divider.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via
// shift-and-subtract, with a one-cycle start / done-pulse handshake.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    step;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] d_work;

    logic [WIDTH:0]   t_run;
    logic [WIDTH:0]   s_run;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // Bit-serial ripple-borrow subtractor; bit WIDTH of the result is the sign.
    function automatic logic [WIDTH:0] sub_borrow(input logic [WIDTH:0] a,
                                                  input logic [WIDTH:0] b);
        logic [WIDTH:0] diff;
        logic           bw;
        bw = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ bw;
            bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        return diff;
    endfunction

    // The partial remainder is always below the divisor, so WIDTH bits hold it
    // and the shifted trial value fits in WIDTH+1 bits.
    always_comb begin
        t_run  = {r_work, q_work[WIDTH-1]};
        s_run  = sub_borrow(t_run, {1'b0, d_work});
        q_next = {q_work[WIDTH-2:0], ~s_run[WIDTH]};
        r_next = s_run[WIDTH] ? t_run[WIDTH-1:0] : s_run[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            step        <= CW'(WIDTH - 1);
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    step <= step - 1'b1;
                    if (step == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Working datapath registers carry no reset; they are always loaded at accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            q_work <= dividend;
            r_work <= '0;
            d_work <= divisor;
        end else if (state == RUN) begin
            q_work <= q_next;
            r_work <= r_next;
        end
    end

endmodule
